// File: rtl/spi_adc_seq_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : spi_adc_seq_if                                                   |
// | Purpose  : Bundles the host-side control/FIFO signals and the analog        |
// |            front-end signals of the scan sequencer into one interface.      |
// | Ports    : host    -> en, start, auto, ch_mask, clk_div, fifo_rd,            |
// |                       fifo_flush, fifo_thresh, int_en                       |
// |            analog  -> comparator (in); dac, mux_sel, sample_and_hold,       |
// |                       pwr_gate, dac_rst (out)                               |
// |            status  -> rd_data, fifo_level, fifo_empty, fifo_full, overflow, |
// |                       busy, scan_done, irq (out)                            |
// |            slave modport = sequencer side, master = host/front-end side.    |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
interface spi_adc_seq_if #(
    parameter int ADC_WIDTH  = 12,
    parameter int NUM_CH     = 4,
    parameter int CH_W       = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) ();
    localparam int c_LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic                      en;
    logic                      start;
    logic                      auto;
    logic [NUM_CH-1:0]         ch_mask;
    logic [DIV_W-1:0]          clk_div;
    logic                      comparator;
    logic                      fifo_rd;
    logic                      fifo_flush;
    logic [c_LVL_W-1:0]        fifo_thresh;
    logic                      int_en;

    logic [ADC_WIDTH-1:0]      dac;
    logic [CH_W-1:0]           mux_sel;
    logic                      sample_and_hold;
    logic                      pwr_gate;
    logic                      dac_rst;
    logic [CH_W+ADC_WIDTH-1:0] rd_data;
    logic [c_LVL_W-1:0]        fifo_level;
    logic                      fifo_empty;
    logic                      fifo_full;
    logic                      overflow;
    logic                      busy;
    logic                      scan_done;
    logic                      irq;

    modport slave (
        input  en, start, auto, ch_mask, clk_div, comparator,
               fifo_rd, fifo_flush, fifo_thresh, int_en,
        output dac, mux_sel, sample_and_hold, pwr_gate, dac_rst,
               rd_data, fifo_level, fifo_empty, fifo_full, overflow,
               busy, scan_done, irq
    );

    modport master (
        output en, start, auto, ch_mask, clk_div, comparator,
               fifo_rd, fifo_flush, fifo_thresh, int_en,
        input  dac, mux_sel, sample_and_hold, pwr_gate, dac_rst,
               rd_data, fifo_level, fifo_empty, fifo_full, overflow,
               busy, scan_done, irq
    );
endinterface
`default_nettype wire

// File: rtl/spi_adc_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : spi_adc_seq                                                      |
// | Purpose  : Multi-channel SAR scan sequencer. Converts every channel enabled |
// |            in ch_mask in ascending order (once per start, or continuously   |
// |            in auto mode) and pushes {channel, result} into a show-ahead     |
// |            FIFO with level/overflow interrupt.                              |
// | Ports    : sys_clk  - system clock                                          |
// |            reset_   - asynchronous active-low reset                         |
// |            bus      - spi_adc_seq_if.slave (host controls, analog front     |
// |                       end, FIFO read side and status)                       |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
module spi_adc_seq #(
    parameter int ADC_WIDTH  = 12,
    parameter int NUM_CH     = 4,
    parameter int CH_W       = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  wire          sys_clk,
    input  wire          reset_,
    spi_adc_seq_if.slave bus
);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;
    localparam int c_BIT_W = $clog2(ADC_WIDTH);
    localparam int c_ENT_W = CH_W + ADC_WIDTH;

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_SAMPLE  = 2'd1;
    localparam logic [1:0] c_CONVERT = 2'd2;
    localparam logic [1:0] c_STORE   = 2'd3;

    localparam logic [ADC_WIDTH-1:0] c_DAC_ONE = ADC_WIDTH'(1);
    localparam logic [c_BIT_W-1:0]   c_BIT_ONE = c_BIT_W'(1);
    localparam logic [c_BIT_W-1:0]   c_BIT_MSB = c_BIT_W'(ADC_WIDTH - 1);
    localparam logic [DIV_W-1:0]     c_CNT_ONE = DIV_W'(1);
    localparam logic [c_PTR_W-1:0]   c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_LVL_W-1:0]   c_LVL_ONE = c_LVL_W'(1);
    localparam logic [c_LVL_W-1:0]   c_DEPTH   = c_LVL_W'(FIFO_DEPTH);

    // Returns {found, index} of the lowest set mask bit at or above lo.
    function automatic logic [CH_W:0] f_pick(input logic [NUM_CH-1:0] mask, input int lo);
        logic [CH_W:0] v;
        v = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i >= lo)) v = {1'b1, CH_W'(i)};
        end
        return v;
    endfunction

    // ---------------------------------------------------------------- state
    logic [1:0]           r_state;
    logic [CH_W-1:0]      r_mux_sel;
    logic [ADC_WIDTH-1:0] r_dac;
    logic [c_BIT_W-1:0]   r_bit;
    logic                 r_sh;
    logic                 r_dac_rst;
    logic                 r_busy;
    logic                 r_scan_done;
    logic [DIV_W-1:0]     r_cnt;

    logic [CH_W:0]        w_first;
    logic [CH_W:0]        w_next;
    logic                 w_tick;
    logic [ADC_WIDTH-1:0] w_kept;
    logic                 w_push;

    assign w_first = f_pick(bus.ch_mask, 0);
    assign w_next  = f_pick(bus.ch_mask, int'(r_mux_sel) + 1);
    assign w_tick  = ((r_state == c_SAMPLE) || (r_state == c_CONVERT)) && (r_cnt == bus.clk_div);
    // Trial bit survives only if the comparator says Vin is at or above the trial code.
    assign w_kept  = bus.comparator ? r_dac : (r_dac & ~(c_DAC_ONE << r_bit));
    assign w_push  = (r_state == c_STORE) && bus.en;

    // Tick divider: idle in IDLE, and held at zero through STORE so every
    // SAMPLE starts a fresh period.
    always_ff @(posedge sys_clk or negedge reset_) begin
        if (!reset_) begin
            r_cnt <= '0;
        end else if (!bus.en || (r_state == c_IDLE) || (r_state == c_STORE) || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
        end
    end

    always_ff @(posedge sys_clk or negedge reset_) begin
        if (!reset_) begin
            r_state     <= c_IDLE;
            r_mux_sel   <= '0;
            r_dac       <= '0;
            r_bit       <= '0;
            r_sh        <= 1'b0;
            r_dac_rst   <= 1'b0;
            r_busy      <= 1'b0;
            r_scan_done <= 1'b0;
        end else begin
            r_scan_done <= 1'b0;
            if (!bus.en) begin
                r_state   <= c_IDLE;
                r_mux_sel <= '0;
                r_dac     <= '0;
                r_bit     <= '0;
                r_sh      <= 1'b0;
                r_dac_rst <= 1'b0;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        if ((bus.start || bus.auto) && w_first[CH_W]) begin
                            r_state   <= c_SAMPLE;
                            r_mux_sel <= w_first[CH_W-1:0];
                            r_dac     <= '0;
                            r_sh      <= 1'b1;
                            r_dac_rst <= 1'b1;
                            r_busy    <= 1'b1;
                        end
                    end
                    c_SAMPLE: begin
                        if (w_tick) begin
                            r_state   <= c_CONVERT;
                            r_sh      <= 1'b0;
                            r_dac_rst <= 1'b0;
                            r_bit     <= c_BIT_MSB;
                            r_dac     <= c_DAC_ONE << c_BIT_MSB;
                        end
                    end
                    c_CONVERT: begin
                        if (w_tick) begin
                            if (r_bit == '0) begin
                                // r_dac now holds the finished result for STORE.
                                r_dac   <= w_kept;
                                r_state <= c_STORE;
                            end else begin
                                r_dac <= w_kept | (c_DAC_ONE << (r_bit - c_BIT_ONE));
                                r_bit <= r_bit - c_BIT_ONE;
                            end
                        end
                    end
                    default: begin // c_STORE
                        if (w_next[CH_W]) begin
                            r_state   <= c_SAMPLE;
                            r_mux_sel <= w_next[CH_W-1:0];
                            r_dac     <= '0;
                            r_sh      <= 1'b1;
                            r_dac_rst <= 1'b1;
                        end else begin
                            r_scan_done <= 1'b1;
                            if (bus.auto && w_first[CH_W]) begin
                                r_state   <= c_SAMPLE;
                                r_mux_sel <= w_first[CH_W-1:0];
                                r_dac     <= '0;
                                r_sh      <= 1'b1;
                                r_dac_rst <= 1'b1;
                            end else begin
                                r_state <= c_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                endcase
            end
        end
    end

    // ----------------------------------------------------------------- FIFO
    logic [c_ENT_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;
    logic               r_overflow;

    logic               w_full;
    logic               w_pop;
    logic               w_wr;
    logic [c_LVL_W-1:0] w_thr;

    assign w_full = (r_level == c_DEPTH);
    assign w_pop  = bus.fifo_rd && (r_level != '0);
    // A push into a full FIFO still lands when the same cycle frees a slot.
    assign w_wr   = w_push && (!w_full || w_pop);

    always_ff @(posedge sys_clk) begin
        if (w_wr && !bus.fifo_flush) r_mem[r_wr_ptr] <= {r_mux_sel, r_dac};
    end

    always_ff @(posedge sys_clk or negedge reset_) begin
        if (!reset_) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else if (bus.fifo_flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop) r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            if (w_wr && !w_pop)      r_level <= r_level + c_LVL_ONE;
            else if (!w_wr && w_pop) r_level <= r_level - c_LVL_ONE;
            if (w_push && !w_wr) r_overflow <= 1'b1;
        end
    end

    // A threshold of zero behaves as one so an empty FIFO never interrupts.
    assign w_thr = (bus.fifo_thresh == '0) ? c_LVL_ONE : bus.fifo_thresh;

    // -------------------------------------------------------------- outputs
    assign bus.dac             = r_dac;
    assign bus.mux_sel         = r_mux_sel;
    assign bus.sample_and_hold = r_sh;
    assign bus.dac_rst         = r_dac_rst;
    assign bus.pwr_gate        = r_busy;
    assign bus.busy            = r_busy;
    assign bus.scan_done       = r_scan_done;
    assign bus.rd_data         = (r_level == '0) ? '0 : r_mem[r_rd_ptr];
    assign bus.fifo_level      = r_level;
    assign bus.fifo_empty      = (r_level == '0);
    assign bus.fifo_full       = w_full;
    assign bus.overflow        = r_overflow;
    assign bus.irq             = bus.int_en & ((r_level >= w_thr) | r_overflow);
endmodule
`default_nettype wire

// File: tb/tb_spi_adc_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_spi_adc_seq                                                   |
// | Purpose  : Self-checking bench for spi_adc_seq. An ideal comparator model   |
// |            (Vin >= DAC per channel) closes the SAR loop; expectations come  |
// |            from the scan rules: ascending enabled channels, result == Vin,  |
// |            busy = channels * ((ADC_WIDTH+1)*(clk_div+1)+1) cycles.          |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
module tb_spi_adc_seq;
    localparam int AW  = 12;
    localparam int NCH = 4;
    localparam int CW  = 2;
    localparam int FD  = 8;
    localparam int DW  = 16;

    logic sys_clk = 1'b0;
    logic reset_;
    always #5 sys_clk = ~sys_clk;

    spi_adc_seq_if #(.ADC_WIDTH(AW), .NUM_CH(NCH), .CH_W(CW), .FIFO_DEPTH(FD), .DIV_W(DW)) bus ();

    spi_adc_seq #(.ADC_WIDTH(AW), .NUM_CH(NCH), .CH_W(CW), .FIFO_DEPTH(FD), .DIV_W(DW)) dut (
        .sys_clk (sys_clk),
        .reset_  (reset_),
        .bus     (bus)
    );

    logic [AW-1:0] vin [NCH];
    assign bus.comparator = (vin[bus.mux_sel] >= bus.dac);

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [3:0]         mask;
        logic [15:0]        div;
        logic [3:0][AW-1:0] v;
        int                 exp_busy;
        int                 exp_n;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_dac"},        32'(bus.dac), 0);
        chk({tag, "_mux_sel"},    32'(bus.mux_sel), 0);
        chk({tag, "_sh"},         32'(bus.sample_and_hold), 0);
        chk({tag, "_pwr_gate"},   32'(bus.pwr_gate), 0);
        chk({tag, "_dac_rst"},    32'(bus.dac_rst), 0);
        chk({tag, "_busy"},       32'(bus.busy), 0);
        chk({tag, "_scan_done"},  32'(bus.scan_done), 0);
        chk({tag, "_overflow"},   32'(bus.overflow), 0);
        chk({tag, "_irq"},        32'(bus.irq), 0);
        chk({tag, "_level"},      32'(bus.fifo_level), 0);
        chk({tag, "_empty"},      32'(bus.fifo_empty), 1);
        chk({tag, "_full"},       32'(bus.fifo_full), 0);
        chk({tag, "_rd_data"},    32'(bus.rd_data), 0);
    endtask

    // One start-triggered scan, then drain and compare every entry.
    task automatic run_scan(input logic [3:0] mask, input logic [15:0] div,
                            input logic [3:0][AW-1:0] v, input int exp_busy, input int exp_n);
        int cyc;
        int sd;
        for (int i = 0; i < NCH; i++) vin[i] = v[i];
        bus.ch_mask = mask;
        bus.clk_div = div;
        bus.start   = 1'b1;
        step();
        bus.start   = 1'b0;
        chk("busy_after_start", 32'(bus.busy), 1);
        cyc = 0;
        sd  = 0;
        while (bus.busy && cyc < 2000) begin
            cyc++;
            if (bus.scan_done) sd++;
            step();
        end
        if (bus.scan_done) sd++;
        chk("busy_low_at_end", 32'(bus.busy), 0);
        chk("busy_cycles", 32'(cyc), 32'(exp_busy));
        chk("scan_done_pulses", 32'(sd), 1);
        chk("fifo_level", 32'(bus.fifo_level), 32'(exp_n));
        for (int ch = 0; ch < NCH; ch++) begin
            if (mask[ch]) begin
                chk("rd_data", 32'(bus.rd_data), 32'({CW'(ch), v[ch]}));
                bus.fifo_rd = 1'b1;
                step();
                bus.fifo_rd = 1'b0;
            end
        end
        chk("empty_after_drain", 32'(bus.fifo_empty), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        int got;
        int sd;
        int prev;
        logic [3:0][AW-1:0] rv;
        logic [3:0]  rm;
        logic [15:0] rd;
        logic [31:0] exp_e;

        tbl[0] = '{mask: 4'b0001, div: 16'd3, v: {12'h000, 12'h000, 12'h000, 12'h5A3}, exp_busy: 53,  exp_n: 1};
        tbl[1] = '{mask: 4'b1010, div: 16'd0, v: {12'hFFF, 12'h000, 12'h100, 12'h000}, exp_busy: 28,  exp_n: 2};
        tbl[2] = '{mask: 4'b1111, div: 16'd1, v: {12'h7FF, 12'h800, 12'h001, 12'h000}, exp_busy: 108, exp_n: 4};
        tbl[3] = '{mask: 4'b0100, div: 16'd2, v: {12'h000, 12'hABC, 12'h000, 12'h000}, exp_busy: 40,  exp_n: 1};
        tbl[4] = '{mask: 4'b1001, div: 16'd0, v: {12'h000, 12'h000, 12'h000, 12'hFFF}, exp_busy: 28,  exp_n: 2};

        reset_          = 1'b0;
        bus.en          = 1'b0;
        bus.start       = 1'b0;
        bus.auto        = 1'b0;
        bus.ch_mask     = '0;
        bus.clk_div     = '0;
        bus.fifo_rd     = 1'b0;
        bus.fifo_flush  = 1'b0;
        bus.fifo_thresh = '0;
        bus.int_en      = 1'b0;
        for (int i = 0; i < NCH; i++) vin[i] = '0;
        step();
        step();
        chk_reset_vals("reset");
        reset_ = 1'b1;
        bus.en = 1'b1;
        step();

        // Empty mask: start must leave the block idle.
        bus.ch_mask = 4'b0000;
        bus.start   = 1'b1;
        step();
        bus.start   = 1'b0;
        chk("mask0_busy", 32'(bus.busy), 0);
        chk("mask0_pwr_gate", 32'(bus.pwr_gate), 0);

        // Directed table.
        for (int r = 0; r < 5; r++)
            run_scan(tbl[r].mask, tbl[r].div, tbl[r].v, tbl[r].exp_busy, tbl[r].exp_n);

        // Randomised scans against the timing/result rules.
        for (int r = 0; r < 8; r++) begin
            rm = 4'($urandom_range(1, 15));
            rd = 16'($urandom_range(0, 3));
            for (int i = 0; i < NCH; i++) rv[i] = AW'($urandom);
            run_scan(rm, rd, rv, $countones(rm) * ((AW + 1) * (int'(rd) + 1) + 1), $countones(rm));
        end

        // Auto mode, mask 1010: alternating ch1/ch3, scan_done with each ch3.
        vin[1] = 12'h100;
        vin[3] = 12'hFFF;
        bus.ch_mask = 4'b1010;
        bus.clk_div = '0;
        bus.auto    = 1'b1;
        got = 0;
        sd  = 0;
        cyc = 0;
        while (got < 6 && cyc < 1000) begin
            cyc++;
            bus.fifo_rd = 1'b0;
            if (bus.scan_done) begin
                sd++;
                chk("auto_done_after_ch3", 32'(bus.rd_data[AW+CW-1:AW]), 3);
            end
            if (!bus.fifo_empty) begin
                exp_e = (got % 2 == 0) ? 32'({2'd1, 12'h100}) : 32'({2'd3, 12'hFFF});
                chk("auto_entry", 32'(bus.rd_data), exp_e);
                got++;
                bus.fifo_rd = 1'b1;
            end
            step();
        end
        bus.fifo_rd = 1'b0;
        chk("auto_entries", 32'(got), 6);
        chk("auto_scan_done_count", 32'(sd), 3);
        bus.auto = 1'b0;
        cyc = 0;
        while (bus.busy && cyc < 200) begin cyc++; step(); end
        chk("auto_stop_busy", 32'(bus.busy), 0);
        bus.fifo_flush = 1'b1;
        step();
        bus.fifo_flush = 1'b0;

        // Overflow: auto on one channel, no reads.
        vin[0] = 12'h3C5;
        bus.ch_mask     = 4'b0001;
        bus.int_en      = 1'b1;
        bus.fifo_thresh = 4'd15;
        bus.auto        = 1'b1;
        cyc = 0;
        while (!bus.fifo_full && cyc < 1000) begin cyc++; step(); end
        chk("ovf_full", 32'(bus.fifo_full), 1);
        chk("ovf_level8", 32'(bus.fifo_level), 8);
        chk("ovf_not_yet", 32'(bus.overflow), 0);
        chk("ovf_irq_before", 32'(bus.irq), 0);
        step();
        cyc = 0;
        while (!bus.scan_done && cyc < 200) begin cyc++; step(); end
        chk("ovf_9th_done", 32'(bus.scan_done), 1);
        chk("ovf_set", 32'(bus.overflow), 1);
        chk("ovf_level_still8", 32'(bus.fifo_level), 8);
        chk("ovf_irq", 32'(bus.irq), 1);
        chk("ovf_head", 32'(bus.rd_data), 32'({2'd0, 12'h3C5}));
        bus.auto = 1'b0;
        cyc = 0;
        while (bus.busy && cyc < 200) begin cyc++; step(); end
        bus.fifo_flush = 1'b1;
        step();
        bus.fifo_flush = 1'b0;
        chk("flush_level", 32'(bus.fifo_level), 0);
        chk("flush_overflow", 32'(bus.overflow), 0);
        chk("flush_irq", 32'(bus.irq), 0);
        chk("flush_empty", 32'(bus.fifo_empty), 1);

        // Threshold IRQ.
        for (int i = 0; i < NCH; i++) vin[i] = AW'($urandom);
        bus.fifo_thresh = 4'd3;
        bus.ch_mask     = 4'b0111;
        bus.start       = 1'b1;
        step();
        bus.start       = 1'b0;
        prev = 0;
        cyc  = 0;
        while (bus.busy && cyc < 500) begin
            cyc++;
            step();
            if (int'(bus.fifo_level) != prev) begin
                chk("thr_irq_track", 32'(bus.irq), 32'(int'(bus.fifo_level) >= 3));
                prev = int'(bus.fifo_level);
            end
        end
        chk("thr_level3", 32'(bus.fifo_level), 3);
        chk("thr_irq_high", 32'(bus.irq), 1);
        bus.fifo_rd = 1'b1;
        step();
        bus.fifo_rd = 1'b0;
        chk("thr_level2", 32'(bus.fifo_level), 2);
        chk("thr_irq_low", 32'(bus.irq), 0);
        bus.fifo_thresh = 4'd0;
        bus.fifo_rd = 1'b1;
        step();
        bus.fifo_rd = 1'b0;
        chk("thr0_level1", 32'(bus.fifo_level), 1);
        chk("thr0_irq", 32'(bus.irq), 1);
        bus.int_en = 1'b0;
        #1;
        chk("irq_masked", 32'(bus.irq), 0);
        bus.fifo_flush = 1'b1;
        step();
        bus.fifo_flush = 1'b0;

        // en dropped during the bit-6 trial.
        vin[0] = 12'h5A3;
        bus.ch_mask = 4'b0001;
        bus.clk_div = 16'd1;
        bus.start   = 1'b1;
        step();
        bus.start   = 1'b0;
        cyc = 0;
        while (!(bus.busy && bus.dac[6:0] == 7'h40) && cyc < 200) begin cyc++; step(); end
        chk("en_reached_bit6", 32'(bus.dac[6:0]), 32'h40);
        bus.en = 1'b0;
        step();
        chk("en_busy", 32'(bus.busy), 0);
        chk("en_dac", 32'(bus.dac), 0);
        chk("en_pwr_gate", 32'(bus.pwr_gate), 0);
        chk("en_sh", 32'(bus.sample_and_hold), 0);
        step();
        step();
        chk("en_no_push", 32'(bus.fifo_level), 0);
        bus.en = 1'b1;
        step();
        run_scan(4'b0001, 16'd1, {12'h000, 12'h000, 12'h000, 12'h5A3}, 27, 1);

        // Asynchronous reset mid-scan with three entries queued.
        for (int i = 0; i < NCH; i++) vin[i] = AW'($urandom);
        bus.int_en      = 1'b1;
        bus.fifo_thresh = 4'd1;
        bus.ch_mask     = 4'b1111;
        bus.clk_div     = '0;
        bus.start       = 1'b1;
        step();
        bus.start       = 1'b0;
        cyc = 0;
        while (bus.fifo_level != 4'd3 && cyc < 500) begin cyc++; step(); end
        chk("rst_level3", 32'(bus.fifo_level), 3);
        chk("rst_busy_before", 32'(bus.busy), 1);
        #2 reset_ = 1'b0;
        #1;
        chk_reset_vals("async_reset");
        step();
        reset_ = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/spi_adc_seq.md
# spi_adc_seq

Parametrised successor to the single-channel SAR ADC wrapper: a multi-channel scan sequencer with an integrated SAR engine and a tagged result FIFO. Everything runs on one system clock; the slow SAR bit rate is a clock-enable tick, not a derived clock. The block sits between the register/SPI slave and the analog front end (input mux, S/H, DAC, comparator). It converts every channel enabled in a mask, in ascending order, once per `start` or continuously in auto mode. Results are pushed into a FIFO for the host to drain.

## Interface
- `ADC_WIDTH`, 12: SAR resolution in bits.
- `NUM_CH`, 4: number of analog input channels.
- `CH_W`, 2: channel-tag width; ≥ clog2(NUM_CH).
- `FIFO_DEPTH`, 8: result entries; power of two.
- `DIV_W`, 16: width of the tick divider.

- `sys_clk` in 1: system clock.
- `reset_` in 1: asynchronous active-low reset.
- `en` in 1: global enable; low aborts and holds IDLE.
- `start` in 1: single-cycle pulse; begins one scan.
- `auto` in 1: continuous scanning while high.
- `ch_mask` in NUM_CH: channel enables.
- `clk_div` in DIV_W: tick period = clk_div+1 sys_clk cycles.
- `comparator` in 1: 1 = Vin ≥ DAC.
- `fifo_rd` in 1: pop head entry.
- `fifo_flush` in 1: empty FIFO, clear overflow.
- `fifo_thresh` in clog2(FIFO_DEPTH)+1: IRQ level; 0 is treated as 1.
- `int_en` in 1: IRQ enable.
- `dac` out ADC_WIDTH: SAR trial code.
- `mux_sel` out CH_W: selected channel.
- `sample_and_hold` out 1: high = track.
- `pwr_gate` out 1: analog power, high when not IDLE.
- `dac_rst` out 1: high during SAMPLE.
- `rd_data` out CH_W+ADC_WIDTH: {channel, result} at head (show-ahead).
- `fifo_level` out clog2(FIFO_DEPTH)+1: entry count.
- `fifo_empty`, `fifo_full` out 1 each: FIFO status.
- `overflow` out 1: sticky; a result was dropped.
- `busy` out 1: high when not IDLE.
- `scan_done` out 1: one-cycle pulse after the last channel of a scan is stored.
- `irq` out 1: interrupt request.

## Operation
- States: IDLE, SAMPLE, CONVERT, STORE.
- IDLE → SAMPLE on `start` or `auto`, provided `en`=1 and `ch_mask`≠0.
  - `mux_sel` loads the lowest set mask bit.
  - `start` while busy is ignored.
  - `ch_mask`=0 leaves the block in IDLE.
- SAMPLE, one tick period:
  - `sample_and_hold`=1, `dac_rst`=1, `dac`=0.
- CONVERT, ADC_WIDTH tick periods, MSB first:
  - For bit k, `dac` = kept bits | (1<<k).
  - On the period's closing tick, `comparator`=1 keeps bit k; 0 clears it.
- STORE, one sys_clk cycle:
  - Push {mux_sel, result}.
  - If another enabled channel above `mux_sel` exists, go to SAMPLE with the next set bit.
  - Else pulse `scan_done`, then go to SAMPLE with the lowest set bit if `auto`, or to IDLE otherwise.
- `ch_mask` is sampled when each channel is selected, so mid-scan changes affect only later channels.
- FIFO:
  - Push while full drops the entry and sets `overflow`.
  - Push and pop in the same cycle while full: both happen, no overflow.
  - Pop while empty is ignored.
  - `fifo_flush` wins over a simultaneous push or pop.
- `irq` = `int_en` & (`fifo_level` ≥ max(`fifo_thresh`,1) | `overflow`). Level-sensitive, combinational from registers.
- `en` low, any state: next cycle is IDLE, the tick counter clears, and analog outputs return to reset values. FIFO contents are kept.

## Timing
- Reset values:
  - `dac`=0, `mux_sel`=0, `sample_and_hold`=0, `pwr_gate`=0, `dac_rst`=0.
  - `busy`=0, `scan_done`=0, `overflow`=0, `irq`=0.
  - `fifo_level`=0, `fifo_empty`=1, `fifo_full`=0, `rd_data`=0.
- Tick counter runs only outside IDLE. It clears on IDLE exit and every tick, and ticks when count == `clk_div`. `clk_div`=0 gives a tick every cycle.
- `start` seen in cycle 0 gives SAMPLE in cycle 1, with `busy`=1.
- Per channel: (ADC_WIDTH+1)·(clk_div+1)+1 cycles from SAMPLE entry to the cycle after STORE.
- FIFO entry is visible on `rd_data`/`fifo_level` in the cycle after STORE.
- `fifo_rd` takes effect next cycle.
- `scan_done` coincides with the cycle after the final STORE.

## Test plan
- ADC_WIDTH=12, clk_div=3, ch_mask=4'b0001, comparator model Vin=0x5A3, start pulse:
  - one entry {0,0x5A3};
  - `busy` high for 53 cycles;
  - `scan_done` pulses once.
- ch_mask=4'b1010, auto=1, Vin ch1=0x100, ch3=0xFFF:
  - FIFO receives {1,0x100},{3,0xFFF},{1,0x100}… in order;
  - `scan_done` pulses after each ch3 store.
- FIFO_DEPTH=8, no reads, auto, 9 conversions:
  - `fifo_full`=1 after 8;
  - 9th dropped, `overflow`=1;
  - `irq`=1 with int_en=1;
  - `fifo_flush` → level 0, overflow 0, irq 0.
- fifo_thresh=3, int_en=1:
  - `irq` rises the cycle level reaches 3;
  - one `fifo_rd` drops level to 2 and `irq` to 0.
- `en` dropped mid-CONVERT of bit 6:
  - IDLE next cycle, `dac`=0, `pwr_gate`=0, no FIFO push;
  - a later `start` completes a normal conversion.
- `reset_` asserted mid-scan with 3 entries queued:
  - all outputs reach their reset values immediately, without waiting for a clock edge;
  - `fifo_empty`=1.
